// File: rtl/pitch_pkg.sv
// pitch_pkg: shared widths, ratio constant and FSM state type for the pitch shifter
// Ports: none (package only)
package pitch_pkg;
    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_FRAC_W  = 7;
    localparam int DEFAULT_SHIFT_W = 8;
    localparam int UNITY_RATIO     = 128;
    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_INTERP, S_OUT} state_t;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port delay-line RAM, registered read data, array not reset
// Ports: clk; we/waddr/wdata synchronous write port; raddr read address, rdata valid one cycle later
module sample_ram
    import pitch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/pitch_shift_core.sv
// pitch_shift_core: delay-line pitch shifter with fractional read pointer and linear interpolation
// Ports: clk; reset_n sync active-low; shift_amt Q1.7 ratio sampled at input handshake;
//        in_valid/in_ready/in_data sample input; out_valid/out_ready/out_data sample output
module pitch_shift_core
    import pitch_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int FRAC_W  = DEFAULT_FRAC_W,
    parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);
    localparam int ACC_W  = ADDR_W + FRAC_W;
    localparam int PROD_W = DATA_W + FRAC_W + 1;
    state_t state, state_d;
    logic [ADDR_W-1:0]  wr_ptr, rd_int, raddr;
    logic [ACC_W-1:0]   rd_acc;
    logic [SHIFT_W-1:0] ratio_q;
    logic               primed, in_hs, out_hs;
    logic [DATA_W-1:0]  rdata, a_q, y;
    logic signed [PROD_W-1:0] diff, prod;
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign rd_int = rd_acc[ACC_W-1:FRAC_W];
    assign raddr  = (state == S_RD1) ? rd_int + 1'b1 : rd_int;
    // rdata holds sample b while in S_INTERP; a was captured one cycle earlier
    assign diff = PROD_W'($signed(rdata)) - PROD_W'($signed(a_q));
    assign prod = diff * $signed({{(PROD_W-FRAC_W){1'b0}}, rd_acc[FRAC_W-1:0]});
    assign y    = a_q + DATA_W'(prod >>> FRAC_W);
    sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (in_hs),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   state_d = in_hs ? S_RD0 : S_IDLE;
            S_RD0:    state_d = S_RD1;
            S_RD1:    state_d = S_INTERP;
            S_INTERP: state_d = S_OUT;
            S_OUT:    state_d = out_hs ? S_IDLE : S_OUT;
            default:  state_d = S_IDLE;
        endcase
    end
    // handshake flags are registered from the next state so both read 0 straight out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_acc    <= {1'b1, {(ACC_W-1){1'b0}}};
            primed    <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= state_d == S_IDLE;
            out_valid <= state_d == S_OUT;
            if (in_hs) ratio_q <= shift_amt;
            if (state == S_RD1) a_q <= rdata;
            if (state == S_INTERP) out_data <= primed ? y : '0;
            if (out_hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                rd_acc <= rd_acc + ACC_W'(ratio_q);
                primed <= primed | (&wr_ptr);
            end
        end
    end
endmodule
